test: RTL and testbench

TEST -- requirements
Module: test

---
 rtl/test_pkg.sv | 25 ++
 rtl/test_bitscan.sv | 29 ++
 rtl/test.sv | 106 ++++++++++
 tb/tb_test.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/test_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : test_pkg
//  Brief   : Shared widths and bit offsets of the analysis word.
//  Rev     : 1.0  initial release
// ============================================================================
package test_pkg;

    localparam int WIDTH = 100;
    localparam int CW    = 7;

    localparam int c_pop_lsb  = 0;
    localparam int c_hi_lsb   = 7;
    localparam int c_lo_lsb   = 14;
    localparam int c_zero_bit = 21;
    localparam int c_par_bit  = 22;
    localparam int c_ones_bit = 23;
    localparam int c_lzc_lsb  = 24;
    localparam int c_tzc_lsb  = 31;
    localparam int c_long_lsb = 38;
    localparam int c_runs_lsb = 45;
    localparam int c_pad_lsb  = 52;

endpackage
`default_nettype wire

// File: rtl/test_bitscan.sv
`default_nettype none
// ============================================================================
//  Module  : test_bitscan
//  Brief   : Finds the lowest set bit index of a vector plus a found flag.
//  Rev     : 1.0  initial release
// ============================================================================
module test_bitscan #(
    parameter int WIDTH = 100
) (
    input  logic [WIDTH-1:0]       i_vec,
    output logic [test_pkg::CW-1:0] o_idx,
    output logic                   o_vld
);
    import test_pkg::*;

    // Scanning downward lets the lowest set bit be the last one written.
    always_comb begin
        o_idx = '0;
        o_vld = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = CW'(i);
                o_vld = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/test.sv
`default_nettype none
// ============================================================================
//  Module  : test
//  Brief   : Registered bit-statistics word (counts, scans, runs) of a.
//  Rev     : 1.0  initial release
// ============================================================================
module test #(
    parameter int WIDTH = 100
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b
);
    import test_pkg::*;

    localparam logic [CW-1:0] c_max_idx   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] c_empty_cnt = CW'(WIDTH);

    logic [WIDTH-1:0] w_rev;
    logic [CW-1:0]    w_lo_idx;
    logic             w_lo_vld;
    logic [CW-1:0]    w_hi_raw;
    logic             w_hi_vld;

    logic [CW-1:0]    w_pop;
    logic [CW-1:0]    w_run;
    logic [CW-1:0]    w_long;
    logic [CW-1:0]    w_runs;
    logic             w_prev;
    logic [CW-1:0]    w_hi;
    logic [CW-1:0]    w_lzc;
    logic [CW-1:0]    w_tzc;
    logic [WIDTH-1:0] w_next;
    logic [WIDTH-1:0] r_b;

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_rev
            assign w_rev[g] = a[WIDTH-1-g];
        end
    endgenerate

    test_bitscan #(.WIDTH(WIDTH)) u_scan_lo (
        .i_vec (a),
        .o_idx (w_lo_idx),
        .o_vld (w_lo_vld)
    );

    // Lowest set bit of the reversed word is the leading-zero count of a.
    test_bitscan #(.WIDTH(WIDTH)) u_scan_hi (
        .i_vec (w_rev),
        .o_idx (w_hi_raw),
        .o_vld (w_hi_vld)
    );

    always_comb begin
        w_pop  = '0;
        w_run  = '0;
        w_long = '0;
        w_runs = '0;
        w_prev = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (a[i]) begin
                w_pop = w_pop + 7'd1;
                w_run = w_run + 7'd1;
                if (w_run > w_long) begin
                    w_long = w_run;
                end
                if (!w_prev) begin
                    w_runs = w_runs + 7'd1;
                end
            end else begin
                w_run = '0;
            end
            w_prev = a[i];
        end

        w_hi  = w_hi_vld ? (c_max_idx - w_hi_raw) : '0;
        w_lzc = w_hi_vld ? w_hi_raw : c_empty_cnt;
        w_tzc = w_lo_vld ? w_lo_idx : c_empty_cnt;

        w_next                        = '0;
        w_next[c_pop_lsb  +: CW]      = w_pop;
        w_next[c_hi_lsb   +: CW]      = w_hi;
        w_next[c_lo_lsb   +: CW]      = w_lo_idx;
        w_next[c_zero_bit]            = ~w_lo_vld;
        w_next[c_par_bit]             = ^a;
        w_next[c_ones_bit]            = &a;
        w_next[c_lzc_lsb  +: CW]      = w_lzc;
        w_next[c_tzc_lsb  +: CW]      = w_tzc;
        w_next[c_long_lsb +: CW]      = w_long;
        w_next[c_runs_lsb +: CW]      = w_runs;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_b <= '0;
        end else begin
            r_b <= w_next;
        end
    end

    assign b = r_b;

endmodule
`default_nettype wire

// File: tb/tb_test.sv
`default_nettype none
// ============================================================================
//  Module  : tb_test
//  Brief   : Scoreboard bench for test against a behavioural statistics model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_test;

    localparam int W = 100;

    typedef struct {
        logic [W-1:0] exp;
        logic [W-1:0] stim;
        string        name;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;

    exp_t q[$];
    int   n_checks;
    int   n_fail;

    test #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] v, input logic r);
        logic [W-1:0] e;
        logic [W-1:0] x;
        int hi, lo, lng;
        e = '0;
        if (r) return e;
        hi = -1;
        lo = -1;
        for (int i = W - 1; i >= 0; i--) if (hi < 0 && v[i]) hi = i;
        for (int i = 0; i < W; i++)      if (lo < 0 && v[i]) lo = i;
        lng = 0;
        x   = v;
        while (x != '0) begin
            lng++;
            x = x & (x << 1);
        end
        e[6:0]   = 7'($countones(v));
        e[13:7]  = (hi < 0) ? 7'd0 : 7'(hi);
        e[20:14] = (lo < 0) ? 7'd0 : 7'(lo);
        e[21]    = (v == '0);
        e[22]    = ($countones(v) % 2) == 1;
        e[23]    = (v == {W{1'b1}});
        e[30:24] = (hi < 0) ? 7'd100 : 7'(W - 1 - hi);
        e[37:31] = (lo < 0) ? 7'd100 : 7'(lo);
        e[44:38] = 7'(lng);
        e[51:45] = 7'($countones(v & ~(v << 1)));
        return e;
    endfunction

    task automatic issue(input logic [W-1:0] v, input logic r, input string nm);
        exp_t t;
        @(negedge clk);
        a = v;
        rst = r;
        t.exp  = model(v, r);
        t.stim = v;
        t.name = nm;
        q.push_back(t);
    endtask

    // Monitor: every edge after the first stimulus yields one result.
    always @(posedge clk) begin
        exp_t t;
        #1;
        if (q.size() > 0) begin
            t = q.pop_front();
            n_checks++;
            if (b !== t.exp) begin
                n_fail++;
                $display("FAIL %s: a=%h b=%h expected=%h", t.name, t.stim, b, t.exp);
            end
        end
    end

    initial begin
        logic [W-1:0] v;
        logic         r;
        int           waited;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        a   = '0;

        issue({W{1'b1}}, 1'b1, "reset_ones");
        issue('0, 1'b0, "zero");
        issue({{(W-1){1'b0}}, 1'b1}, 1'b0, "one");
        issue({W{1'b1}}, 1'b0, "all_ones");
        v = '0;
        v[99] = 1'b1;
        v[3:0] = 4'hF;
        issue(v, 1'b0, "b99_low4");
        v = '0;
        for (int i = 0; i < W; i += 2) v[i] = 1'b1;
        issue(v, 1'b0, "even_bits");
        issue(~v, 1'b1, "reset_odd");
        issue(~v, 1'b0, "odd_bits");

        // rst pulses between edges must be invisible
        issue(v, 1'b0, "rst_glitch");
        #1 rst = 1'b1;
        #1 rst = 1'b0;

        for (int n = 0; n < 200; n++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0: v = v & {$urandom, $urandom, $urandom, $urandom}
                         & {$urandom, $urandom, $urandom, $urandom};
                1: v = v | {$urandom, $urandom, $urandom, $urandom}
                         | {$urandom, $urandom, $urandom, $urandom};
                2: v = (v << $urandom_range(0, 99)) >> $urandom_range(0, 99);
                default: ;
            endcase
            r = ($urandom_range(0, 9) == 0);
            issue(v, r, "random");
        end

        waited = 0;
        while (q.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: pending=%0d required=0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
